reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 16, register count; power of two, at least 4.
REQ-003 SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to the read ports.
REQ-004 SHALL derive AW = log2(NREGS) and PC_IDX = NREGS-1 internally.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port waddr, input, AW, write index.
REQ-009 SHALL have port wdata, input, XLEN, write data.
REQ-010 SHALL have ports raddr1 and raddr2, input, AW, read indices.
REQ-011 SHALL have port pc_plus, input, XLEN, value returned when PC_IDX is read.
REQ-012 SHALL have ports rdata1 and rdata2, output, XLEN, read data.
REQ-013 SHALL have port iss_valid, input, 1; an instruction writing iss_rd issues this cycle.
REQ-014 SHALL have port iss_rd, input, AW, destination of the issuing instruction.
REQ-015 SHALL have port hazard, output, 1, read operand pending (stall request).
REQ-016 SHALL have port clr_req, input, 1, request a bulk clear of all registers.
REQ-017 SHALL have port clr_busy, output, 1, bulk clear in progress.

Function
REQ-018 SHALL store NREGS-1 registers (indices 0..PC_IDX-1). Index PC_IDX SHALL have no storage.
REQ-019 SHALL perform the write on the rising edge when we=1, waddr!=PC_IDX and the FSM is IDLE. A write to PC_IDX SHALL be dropped.
REQ-020 SHALL make reads combinational. Read of PC_IDX SHALL return pc_plus. Otherwise, with BYPASS=1, we=1, FSM IDLE and waddr equal to the read index, it SHALL return wdata. Otherwise it SHALL return the stored value.
REQ-021 SHALL keep a pending bit per index. It is set on the rising edge when iss_valid=1 and iss_rd!=PC_IDX.
REQ-022 SHALL clear the pending bit of waddr on a write accepted under REQ-019.
REQ-023 SHALL let set win when the set and clear of the same index coincide.
REQ-024 SHALL drive hazard=1 when, for either read port, the index is not PC_IDX, pending is 1, and the bit is not being cleared this cycle with BYPASS=1. It SHALL also drive hazard=1 whenever the FSM is CLEAR.
REQ-025 SHALL implement a two-state FSM, IDLE and CLEAR.
REQ-026 SHALL leave IDLE for CLEAR on a rising edge with clr_req=1. That edge SHALL load the counter with 0 and zero every pending bit; an iss_valid on that edge SHALL be dropped.
REQ-027 SHALL zero register[counter] on each rising edge in CLEAR and increment the counter.
REQ-028 SHALL return to IDLE after the edge that clears index PC_IDX-1. Clear latency is NREGS-1 cycles.
REQ-029 SHALL ignore we, iss_valid and clr_req while in CLEAR.
REQ-030 SHALL drive clr_busy=1 exactly while in CLEAR.
REQ-031 SHALL keep reads combinational during CLEAR and return the current stored values (partially cleared).
REQ-032 SHALL use an AW-bit counter; it never exceeds PC_IDX-1.

Reset
REQ-033 SHALL, on rst=1 and without waiting for clk, zero all registers, zero all pending bits, set the FSM to IDLE and zero the counter.
REQ-034 SHALL, when rst asserts mid-CLEAR, abort the clear and hold the reset state until rst deasserts.
REQ-035 SHALL set the outputs under reset to: hazard=0; clr_busy=0; rdata equal to 0, or to pc_plus for PC_IDX.

Structure
REQ-036 SHALL place the FSM state enum (IDLE, CLEAR) and the default XLEN/NREGS constants in the shared package regfile_pkg.
REQ-037 SHALL place the pending-bit vector and hazard logic in the sub-module reg_scoreboard, parameterised by NREGS.

Verification
REQ-038 SHALL cover write then read: write 0xDEADBEEF to r3; next cycle raddr1=3 -> rdata1=0xDEADBEEF; raddr2=15 with pc_plus=0x100 -> rdata2=0x100.
REQ-039 SHALL cover bypass: we=1, waddr=5, wdata=0x12345678 with raddr1=5 in the same cycle -> rdata1=0x12345678 when BYPASS=1; old value when BYPASS=0.
REQ-040 SHALL cover the scoreboard: issue rd=7; next cycle raddr2=7 -> hazard=1; write r7 -> hazard=0 that cycle with BYPASS=1; simultaneous issue and write of r7 -> pending stays 1.
REQ-041 SHALL cover the dropped write: we=1, waddr=15, wdata=0xFFFFFFFF -> no register changes; raddr1=15 still returns pc_plus.
REQ-042 SHALL cover bulk clear: fill r0..r14 with nonzero values, pulse clr_req -> clr_busy=1 for exactly 15 cycles with hazard=1 and we ignored; then all registers read 0 and all pending bits are 0.
REQ-043 SHALL cover async reset: assert rst on the 6th cycle of CLEAR, between clock edges -> clr_busy=0 immediately; after release all registers read 0 and the FSM is IDLE.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types: bulk-clear FSM states and default geometry.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Purpose: per-register pending bits and operand hazard (stall) detection.
// Latency: set/clear take effect on the next edge; hazard is combinational.
// Backpressure: hazard is the stall request; forced high while busy.
import regfile_pkg::*;

module reg_scoreboard #(
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          set_vld,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic          busy,
    output logic          hazard
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic             haz1;
    logic             haz2;

    // Set is applied after clear so a coinciding issue keeps the bit pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_vld) pend_d[clr_idx] = 1'b0;
        if (set_vld) pend_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pend_q <= '0;
        else if (flush) pend_q <= '0;
        else            pend_q <= pend_d;
    end

    // Without bypass the forwarded value is not visible, so the clear cannot hide the hazard.
    always_comb begin
        haz1 = (raddr1 != PC_IDX) && pend_q[raddr1] &&
               !((BYPASS != 0) && clr_vld && (clr_idx == raddr1));
        haz2 = (raddr2 != PC_IDX) && pend_q[raddr2] &&
               !((BYPASS != 0) && clr_vld && (clr_idx == raddr2));
        hazard = busy | haz1 | haz2;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Purpose: 2R/1W register file with PC read alias, write bypass, scoreboard and bulk clear.
// Latency: reads combinational; writes land on the next edge; bulk clear takes NREGS-1 cycles.
// Backpressure: hazard requests a stall; writes/issues/clear requests are ignored while clr_busy.
import regfile_pkg::*;

module reg_file_sb #(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    input  logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            hazard,
    input  logic            clr_req,
    output logic            clr_busy
);

    localparam logic [AW-1:0] PC_IDX   = AW'(NREGS - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 2);

    logic [XLEN-1:0] regs [NREGS-1];
    clr_state_t      state_q;
    clr_state_t      state_d;
    logic [AW-1:0]   cnt_q;
    logic            idle;
    logic            wr_acc;
    logic            iss_acc;

    assign idle     = (state_q == IDLE);
    assign clr_busy = (state_q == CLEAR);
    // rst gates wr_acc so the bypass path cannot leak wdata while reset holds.
    assign wr_acc   = we && !rst && idle && (waddr != PC_IDX);
    assign iss_acc  = iss_valid && idle && !clr_req && (iss_rd != PC_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            if (idle) begin
                cnt_q <= '0;
                if (wr_acc) regs[waddr] <= wdata;
            end else begin
                regs[cnt_q] <= '0;
                cnt_q       <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        if (a == PC_IDX) return pc_plus;
        if ((BYPASS != 0) && wr_acc && (waddr == a)) return wdata;
        return regs[a];
    endfunction

    assign rdata1 = rd_port(raddr1);
    assign rdata2 = rd_port(raddr2);

    reg_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .flush   (idle && clr_req),
        .set_vld (iss_acc),
        .set_idx (iss_rd),
        .clr_vld (wr_acc),
        .clr_idx (waddr),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .busy    (clr_busy),
        .hazard  (hazard)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against a behavioural model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr1, raddr2;
    logic [31:0] pc_plus;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        clr_req;
    logic [31:0] rdata1, rdata2, rdata1_nb, rdata2_nb;
    logic        hazard, hazard_nb, clr_busy, clr_busy_nb;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: register contents, pending flags, clear progress.
    logic [31:0] m_regs [15];
    bit          m_pend [15];
    bit          m_busy;
    int          m_cidx;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(16), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .pc_plus(pc_plus),
        .rdata1(rdata1), .rdata2(rdata2), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .hazard(hazard), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    reg_file_sb #(.XLEN(32), .NREGS(16), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .pc_plus(pc_plus),
        .rdata1(rdata1_nb), .rdata2(rdata2_nb), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .hazard(hazard_nb), .clr_req(clr_req), .clr_busy(clr_busy_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [3:0] a, input bit bp);
        if (a == 4'd15) return pc_plus;
        if (bp && we && !rst && !m_busy && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit m_haz_port(input logic [3:0] a, input bit bp);
        if (a == 4'd15 || !m_pend[a]) return 1'b0;
        if (bp && we && !rst && !m_busy && waddr == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_haz(input bit bp);
        return m_busy || m_haz_port(raddr1, bp) || m_haz_port(raddr2, bp);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 15; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_cidx = 0;
    endtask

    task automatic m_edge();
        if (rst) begin
            m_reset();
        end else if (m_busy) begin
            m_regs[m_cidx] = '0;
            m_cidx++;
            if (m_cidx == 15) m_busy = 1'b0;
        end else begin
            if (we && waddr != 4'd15) begin
                m_regs[waddr] = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (clr_req) begin
                m_busy = 1'b1;
                m_cidx = 0;
                for (int i = 0; i < 15; i++) m_pend[i] = 1'b0;
            end else if (iss_valid && iss_rd != 4'd15) begin
                m_pend[iss_rd] = 1'b1;
            end
        end
    endtask

    // Inputs are applied just after the falling edge; outputs checked 1ns later.
    task automatic cyc();
        #1;
        chk("rdata1", rdata1, m_rd(raddr1, 1'b1));
        chk("rdata2", rdata2, m_rd(raddr2, 1'b1));
        chk("rdata1_nobypass", rdata1_nb, m_rd(raddr1, 1'b0));
        chk("rdata2_nobypass", rdata2_nb, m_rd(raddr2, 1'b0));
        chk("hazard", {31'd0, hazard}, {31'd0, m_haz(1'b1)});
        chk("hazard_nobypass", {31'd0, hazard_nb}, {31'd0, m_haz(1'b0)});
        chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy});
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
    endtask

    task automatic sweep_reads();
        idle_inputs();
        for (int i = 0; i < 16; i += 2) begin
            raddr1 = 4'(i); raddr2 = 4'(i + 1);
            cyc();
        end
    endtask

    task automatic fill_regs();
        for (int i = 0; i < 15; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = $urandom | 32'h1;
            iss_valid = (i % 3 == 0); iss_rd = 4'(14 - i);
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        int busy_cycles;
        m_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 4'd2; raddr2 = 4'd15;
        pc_plus = 32'h100; iss_valid = 1'b0; iss_rd = '0; clr_req = 1'b0;
        @(negedge clk);
        we = 1'b1; waddr = 4'd2; wdata = 32'hAAAA5555;
        cyc();
        rst = 1'b0; idle_inputs();
        cyc();

        // Write then read, including the PC alias.
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF;
        cyc();
        we = 1'b0; raddr1 = 4'd3; raddr2 = 4'd15;
        cyc();
        chk("r3_readback", rdata1, 32'hDEADBEEF);

        // Same-cycle bypass.
        we = 1'b1; waddr = 4'd5; wdata = 32'h12345678; raddr1 = 4'd5;
        #1;
        chk("bypass_on", rdata1, 32'h12345678);
        chk("bypass_off_old", rdata1_nb, 32'h0);
        #1;
        cyc();

        // Scoreboard: issue, stall, write clears, coincident issue+write keeps pending.
        idle_inputs(); iss_valid = 1'b1; iss_rd = 4'd7;
        cyc();
        iss_valid = 1'b0; raddr2 = 4'd7; raddr1 = 4'd3;
        cyc();
        we = 1'b1; waddr = 4'd7; wdata = 32'h77;
        cyc();
        iss_valid = 1'b1; iss_rd = 4'd7; we = 1'b1; waddr = 4'd7; wdata = 32'h78;
        cyc();
        idle_inputs();
        #1;
        chk("pend_kept", {31'd0, hazard}, 32'd1);
        #1;
        cyc();
        we = 1'b1; waddr = 4'd7; wdata = 32'h79;
        cyc();

        // Write to the PC index is dropped.
        we = 1'b1; waddr = 4'd15; wdata = 32'hFFFFFFFF; raddr1 = 4'd15; pc_plus = 32'h200;
        cyc();
        sweep_reads();

        // Bulk clear with ignored writes/issues/requests.
        fill_regs();
        clr_req = 1'b1;
        cyc();
        busy_cycles = 0;
        for (int k = 0; k < 40 && clr_busy; k++) begin
            we = 1'b1; waddr = 4'($urandom_range(0, 14)); wdata = $urandom;
            iss_valid = 1'b1; iss_rd = 4'($urandom_range(0, 14)); clr_req = $urandom_range(0, 1);
            raddr1 = 4'($urandom_range(0, 15)); raddr2 = 4'($urandom_range(0, 15));
            busy_cycles++;
            cyc();
        end
        chk("clr_busy_cycles", busy_cycles, 32'd15);
        sweep_reads();

        // Async reset during the 6th cycle of a clear.
        fill_regs();
        clr_req = 1'b1;
        cyc();
        idle_inputs(); raddr1 = 4'd14; raddr2 = 4'd13;
        for (int k = 0; k < 5; k++) cyc();
        #2 rst = 1'b1;
        #1;
        chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_r14", rdata1, 32'd0);
        m_reset();
        @(negedge clk);
        cyc();
        rst = 1'b0;
        sweep_reads();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            we = ($urandom_range(0, 1) == 1); waddr = 4'($urandom);
            wdata = $urandom; raddr1 = 4'($urandom); raddr2 = 4'($urandom);
            iss_valid = ($urandom_range(0, 2) == 0); iss_rd = 4'($urandom);
            clr_req = ($urandom_range(0, 59) == 0); pc_plus = $urandom;
            if ($urandom_range(0, 3) == 0 && m_pend[4'($urandom_range(0, 14))])
                raddr1 = iss_rd;
            cyc();
        end
        sweep_reads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
